// File: rtl/pmem_arbiter_if.sv
// Signal bundle between the I/D cache clients, the pmem arbiter and physical memory.
// The slave modport is the arbiter's view; master is the clients-plus-memory side.
interface pmem_arbiter_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned LINE_W = 256
);

  logic              i_read;
  logic              i_write;
  logic [ADDR_W-1:0] i_address;
  logic [LINE_W-1:0] i_wdata;
  logic              i_resp;
  logic [LINE_W-1:0] i_rdata;

  logic              d_read;
  logic              d_write;
  logic [ADDR_W-1:0] d_address;
  logic [LINE_W-1:0] d_wdata;
  logic              d_resp;
  logic [LINE_W-1:0] d_rdata;

  logic              pmem_read;
  logic              pmem_write;
  logic [ADDR_W-1:0] pmem_address;
  logic [LINE_W-1:0] pmem_wdata;
  logic              pmem_resp;
  logic [LINE_W-1:0] pmem_rdata;
  logic              pmem_error;

  logic              err;

  modport slave (
    input  i_read, i_write, i_address, i_wdata,
    input  d_read, d_write, d_address, d_wdata,
    input  pmem_resp, pmem_rdata, pmem_error,
    output i_resp, i_rdata, d_resp, d_rdata,
    output pmem_read, pmem_write, pmem_address, pmem_wdata,
    output err
  );

  modport master (
    output i_read, i_write, i_address, i_wdata,
    output d_read, d_write, d_address, d_wdata,
    output pmem_resp, pmem_rdata, pmem_error,
    input  i_resp, i_rdata, d_resp, d_rdata,
    input  pmem_read, pmem_write, pmem_address, pmem_wdata,
    input  err
  );

endinterface

// File: rtl/pmem_arbiter.sv
// Round-robin arbiter merging I-cache and D-cache line requests onto one pmem channel.
// The granted request is latched so memory sees a stable command until pmem_resp.
module pmem_arbiter #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned LINE_W = 256
) (
  input logic           clk,
  input logic           rst,
  pmem_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ISSUE   = 2'd1,
    ST_RESPOND = 2'd2,
    ST_GAP     = 2'd3
  } state_e;

  typedef enum logic {
    CL_I = 1'b0,
    CL_D = 1'b1
  } client_e;

  typedef struct packed {
    logic              write;
    logic [ADDR_W-1:0] addr;
    logic [LINE_W-1:0] wdata;
  } req_t;

  state_e            state_q;
  client_e           last_grant_q;
  req_t              req_q;
  logic              pmem_read_q;
  logic              pmem_write_q;
  logic              i_resp_q;
  logic              d_resp_q;
  logic [LINE_W-1:0] i_rdata_q;
  logic [LINE_W-1:0] d_rdata_q;
  logic              err_q;

  logic              i_req_c;
  logic              d_req_c;
  client_e           gnt_d;
  req_t              req_d;

  assign i_req_c = bus.i_read | bus.i_write;
  assign d_req_c = bus.d_read | bus.d_write;

  // A lone requester wins outright; on contention the client that lost last time goes.
  // A client raising both read and write is treated as a write.
  always_comb begin
    gnt_d = CL_I;
    if (i_req_c && d_req_c) begin
      gnt_d = (last_grant_q == CL_I) ? CL_D : CL_I;
    end else if (d_req_c) begin
      gnt_d = CL_D;
    end
    if (gnt_d == CL_D) begin
      req_d = '{write: bus.d_write, addr: bus.d_address, wdata: bus.d_wdata};
    end else begin
      req_d = '{write: bus.i_write, addr: bus.i_address, wdata: bus.i_wdata};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      last_grant_q <= CL_I;
      req_q        <= '0;
      pmem_read_q  <= 1'b0;
      pmem_write_q <= 1'b0;
      i_resp_q     <= 1'b0;
      d_resp_q     <= 1'b0;
      i_rdata_q    <= '0;
      d_rdata_q    <= '0;
      err_q        <= 1'b0;
    end else begin
      i_resp_q <= 1'b0;
      d_resp_q <= 1'b0;
      if (bus.pmem_error) begin
        err_q <= 1'b1;
      end

      case (state_q)
        ST_IDLE: begin
          if (i_req_c || d_req_c) begin
            req_q        <= req_d;
            last_grant_q <= gnt_d;
            pmem_read_q  <= ~req_d.write;
            pmem_write_q <= req_d.write;
            state_q      <= ST_ISSUE;
          end
        end

        // Command stays frozen in req_q; live client inputs are not looked at here.
        ST_ISSUE: begin
          if (bus.pmem_resp) begin
            pmem_read_q  <= 1'b0;
            pmem_write_q <= 1'b0;
            state_q      <= ST_RESPOND;
            if (last_grant_q == CL_D) begin
              d_rdata_q <= bus.pmem_rdata;
              d_resp_q  <= 1'b1;
            end else begin
              i_rdata_q <= bus.pmem_rdata;
              i_resp_q  <= 1'b1;
            end
          end
        end

        ST_RESPOND: state_q <= ST_GAP;

        ST_GAP: state_q <= ST_IDLE;

        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.pmem_read    = pmem_read_q;
  assign bus.pmem_write   = pmem_write_q;
  assign bus.pmem_address = req_q.addr;
  assign bus.pmem_wdata   = req_q.wdata;
  assign bus.i_resp       = i_resp_q;
  assign bus.i_rdata      = i_rdata_q;
  assign bus.d_resp       = d_resp_q;
  assign bus.d_rdata      = d_rdata_q;
  assign bus.err          = err_q;

endmodule

// File: tb/tb_pmem_arbiter.sv
// Bench for pmem_arbiter: directed scenarios plus randomized traffic against a
// transaction-level reference model with a behavioural memory responder.
module tb_pmem_arbiter;

  localparam int unsigned ADDR_W       = 32;
  localparam int unsigned LINE_W       = 256;
  localparam int          LAT_RAND_MAX = 6;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  pmem_arbiter_if #(.ADDR_W(ADDR_W), .LINE_W(LINE_W)) bus ();

  pmem_arbiter #(.ADDR_W(ADDR_W), .LINE_W(LINE_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_errs   = 0;

  task automatic check_eq(input string tag, input logic [LINE_W-1:0] got,
                          input logic [LINE_W-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model: one outstanding transaction, arbitration allowed from cycle arb_ok
  int                cyc    = 0;
  int                arb_ok = 0;
  bit                m_busy, m_write, m_owner, m_last, m_iresp, m_dresp, m_err;
  logic [ADDR_W-1:0] m_addr;
  logic [LINE_W-1:0] m_wdata, m_irdata, m_drdata;

  // Client stimulus state (index 0 = I, 1 = D)
  bit                pend[2];
  int                waitc[2];
  bit                auto_req[2];
  logic              cur_rd[2];
  logic              cur_wr[2];
  int                req_pct  = 100;
  bit                scramble = 0;
  int                resp_log[$];

  // Memory responder state
  int                mem_lat  = 3;
  bit                mem_rand = 0;
  bit                spurious = 0;
  int                mem_wait = -1;
  logic [LINE_W-1:0] mem_last_rdata = '0;

  int                low_cnt = 99;
  bit                rw_prev = 0;

  function automatic logic [LINE_W-1:0] rand_line();
    logic [LINE_W-1:0] v;
    for (int i = 0; i < int'(LINE_W / 32); i++) v[i*32 +: 32] = $urandom();
    return v;
  endfunction

  function automatic logic [ADDR_W-1:0] rand_addr();
    logic [ADDR_W-1:0] a;
    a      = $urandom();
    a[4:0] = 5'd0;
    return a;
  endfunction

  function automatic int lat_max();
    return mem_rand ? LAT_RAND_MAX : mem_lat;
  endfunction

  task automatic drive_client(input int c, input logic rd, input logic wr,
                              input logic [ADDR_W-1:0] a, input logic [LINE_W-1:0] w);
    cur_rd[c] = rd;
    cur_wr[c] = wr;
    if (c == 1) begin
      bus.d_read = rd; bus.d_write = wr; bus.d_address = a; bus.d_wdata = w;
    end else begin
      bus.i_read = rd; bus.i_write = wr; bus.i_address = a; bus.i_wdata = w;
    end
  endtask

  task automatic issue(input int c, input logic rd, input logic wr,
                       input logic [ADDR_W-1:0] a, input logic [LINE_W-1:0] w);
    drive_client(c, rd, wr, a, w);
    pend[c]  = 1'b1;
    waitc[c] = 0;
  endtask

  task automatic issue_rand(input int c);
    int op;
    op = int'($urandom_range(0, 2));
    issue(c, op != 1, op != 0, rand_addr(), rand_line());
  endtask

  task automatic model_update();
    bit ireq, dreq;
    if (rst) begin
      m_busy = 0; m_last = 0; m_iresp = 0; m_dresp = 0; m_err = 0;
      m_irdata = '0; m_drdata = '0;
      arb_ok = cyc + 1;
    end else begin
      m_iresp = 0;
      m_dresp = 0;
      if (bus.pmem_error) m_err = 1;
      if (m_busy) begin
        if (bus.pmem_resp) begin
          m_busy = 0;
          arb_ok = cyc + 3;
          if (m_owner) begin m_dresp = 1; m_drdata = bus.pmem_rdata; end
          else begin m_iresp = 1; m_irdata = bus.pmem_rdata; end
        end
      end else if (cyc >= arb_ok) begin
        ireq = bus.i_read | bus.i_write;
        dreq = bus.d_read | bus.d_write;
        if (ireq | dreq) begin
          m_owner = (ireq & dreq) ? ~m_last : dreq;
          m_last  = m_owner;
          m_busy  = 1;
          m_write = m_owner ? bus.d_write : bus.i_write;
          m_addr  = m_owner ? bus.d_address : bus.i_address;
          m_wdata = m_owner ? bus.d_wdata : bus.i_wdata;
        end
      end
    end
  endtask

  task automatic compare();
    bit rw;
    check_eq("rd_wr_excl", LINE_W'(bus.pmem_read & bus.pmem_write), LINE_W'(0));
    check_eq("pmem_read", LINE_W'(bus.pmem_read), LINE_W'(m_busy & ~m_write));
    check_eq("pmem_write", LINE_W'(bus.pmem_write), LINE_W'(m_busy & m_write));
    if (m_busy) begin
      check_eq("pmem_address", LINE_W'(bus.pmem_address), LINE_W'(m_addr));
      check_eq("pmem_wdata", bus.pmem_wdata, m_wdata);
    end
    check_eq("i_resp", LINE_W'(bus.i_resp), LINE_W'(m_iresp));
    check_eq("d_resp", LINE_W'(bus.d_resp), LINE_W'(m_dresp));
    check_eq("i_rdata", bus.i_rdata, m_irdata);
    check_eq("d_rdata", bus.d_rdata, m_drdata);
    check_eq("err", LINE_W'(bus.err), LINE_W'(m_err));
    rw = bus.pmem_read | bus.pmem_write;
    if (rst) low_cnt = 99;
    else if (rw && !rw_prev) begin
      check_eq("rw_gap", LINE_W'(low_cnt >= 2), LINE_W'(1));
      low_cnt = 0;
    end else if (!rw) low_cnt++;
    rw_prev = rw;
  endtask

  task automatic clients();
    logic r;
    for (int c = 0; c < 2; c++) begin
      r = (c == 1) ? bus.d_resp : bus.i_resp;
      if (rst) waitc[c] = 0;
      if (pend[c] && r) begin
        check_eq(c == 1 ? "wait_d" : "wait_i",
                 LINE_W'(waitc[c] <= 2 * (lat_max() + 6)), LINE_W'(1));
        pend[c] = 1'b0;
        resp_log.push_back(c);
        drive_client(c, 1'b0, 1'b0, rand_addr(), rand_line());
      end else if (pend[c]) begin
        waitc[c]++;
        // The owner's live inputs must not leak into the latched command
        if (scramble && m_busy && int'(m_owner) == c)
          drive_client(c, cur_rd[c], cur_wr[c], rand_addr(), rand_line());
      end
      if (!pend[c] && auto_req[c] && int'($urandom_range(0, 99)) < req_pct) issue_rand(c);
    end
  endtask

  task automatic memory();
    bus.pmem_resp  = 1'b0;
    bus.pmem_rdata = rand_line();
    if (bus.pmem_read | bus.pmem_write) begin
      if (mem_wait < 0) mem_wait = (mem_rand ? int'($urandom_range(1, LAT_RAND_MAX)) : mem_lat) - 1;
      if (mem_wait == 0) begin
        mem_last_rdata = rand_line();
        bus.pmem_rdata = mem_last_rdata;
        bus.pmem_resp  = 1'b1;
        mem_wait       = -1;
      end else mem_wait--;
    end else begin
      mem_wait = -1;
      if (spurious && $urandom_range(0, 15) == 0) bus.pmem_resp = 1'b1;
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    model_update();
    compare();
    clients();
    memory();
  endtask

  task automatic wait_log(input int n, input int bound, input string tag);
    int k;
    k = 0;
    while (resp_log.size() < n && k < bound) begin step(); k++; end
    check_eq(tag, LINE_W'(resp_log.size() >= n), LINE_W'(1));
  endtask

  task automatic drain(input string tag);
    int k;
    k = 0;
    while ((pend[0] || pend[1]) && k < 300) begin step(); k++; end
    check_eq(tag, LINE_W'(pend[0] | pend[1]), LINE_W'(0));
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n;
    int seen;
    logic [LINE_W-1:0] w;

    drive_client(0, 1'b0, 1'b0, '0, '0);
    drive_client(1, 1'b0, 1'b0, '0, '0);
    bus.pmem_resp  = 1'b0;
    bus.pmem_rdata = '0;
    bus.pmem_error = 1'b0;
    auto_req[0] = 0; auto_req[1] = 0;
    pend[0] = 0; pend[1] = 0;

    // Reset state
    rst = 1'b1;
    step();
    step();
    check_eq("rst_pmem_read", LINE_W'(bus.pmem_read), LINE_W'(0));
    check_eq("rst_pmem_write", LINE_W'(bus.pmem_write), LINE_W'(0));
    check_eq("rst_pmem_address", LINE_W'(bus.pmem_address), LINE_W'(0));
    check_eq("rst_pmem_wdata", bus.pmem_wdata, LINE_W'(0));
    check_eq("rst_resp", LINE_W'({bus.i_resp, bus.d_resp}), LINE_W'(0));
    check_eq("rst_i_rdata", bus.i_rdata, LINE_W'(0));
    check_eq("rst_err", LINE_W'(bus.err), LINE_W'(0));

    // I read 0x40 alone with a 25-cycle memory
    rst = 1'b0;
    mem_lat = 25;
    resp_log.delete();
    issue(0, 1'b1, 1'b0, 32'h40, rand_line());
    step();
    check_eq("t1_pmem_read_edge1", LINE_W'(bus.pmem_read), LINE_W'(1));
    check_eq("t1_pmem_address", LINE_W'(bus.pmem_address), LINE_W'(32'h40));
    n = 1;
    while (resp_log.size() == 0 && n < 200) begin step(); n++; end
    check_eq("t1_latency", LINE_W'(n), LINE_W'(26));
    check_eq("t1_i_resp", LINE_W'(bus.i_resp), LINE_W'(1));
    check_eq("t1_i_rdata", bus.i_rdata, mem_last_rdata);
    check_eq("t1_d_resp", LINE_W'(bus.d_resp), LINE_W'(0));
    step();
    check_eq("t1_i_resp_pulse", LINE_W'(bus.i_resp), LINE_W'(0));
    check_eq("t1_i_rdata_hold", bus.i_rdata, mem_last_rdata);

    // Simultaneous I read and D write after reset: D first
    pulse_reset();
    mem_lat = 4;
    resp_log.delete();
    issue(0, 1'b1, 1'b0, 32'h80, rand_line());
    issue(1, 1'b0, 1'b1, 32'h100, rand_line());
    wait_log(2, 300, "t2_both_done");
    check_eq("t2_first_d", LINE_W'(resp_log.size() > 0 ? resp_log[0] : -1), LINE_W'(1));
    check_eq("t2_second_i", LINE_W'(resp_log.size() > 1 ? resp_log[1] : -1), LINE_W'(0));

    // D write 0x20 with inputs scrambled after grant
    w = rand_line();
    mem_lat = 5;
    scramble = 1;
    resp_log.delete();
    issue(1, 1'b0, 1'b1, 32'h20, w);
    n = 0;
    seen = 0;
    while (resp_log.size() == 0 && n < 100) begin
      step();
      n++;
      if (bus.pmem_write) begin
        seen++;
        check_eq("t3_address_held", LINE_W'(bus.pmem_address), LINE_W'(32'h20));
        check_eq("t3_wdata_held", bus.pmem_wdata, w);
      end
    end
    check_eq("t3_write_cycles", LINE_W'(seen), LINE_W'(5));
    scramble = 0;

    // Both clients continuously requesting: D,I,D,I,D,I
    pulse_reset();
    mem_lat = 3;
    req_pct = 100;
    auto_req[0] = 1; auto_req[1] = 1;
    issue_rand(0);
    issue_rand(1);
    resp_log.delete();
    wait_log(6, 400, "t4_six_done");
    for (int i = 0; i < 6; i++)
      check_eq($sformatf("t4_grant%0d", i), LINE_W'(i < resp_log.size() ? resp_log[i] : -1),
               LINE_W'((i % 2 == 0) ? 1 : 0));
    auto_req[0] = 0; auto_req[1] = 0;
    drain("t4_drain");

    // Reset mid-ISSUE
    pulse_reset();
    mem_lat = 20;
    issue(0, 1'b1, 1'b0, 32'h40, rand_line());
    repeat (3) step();
    check_eq("t5_busy", LINE_W'(bus.pmem_read), LINE_W'(1));
    rst = 1'b1;
    step();
    check_eq("t5_pmem_read", LINE_W'(bus.pmem_read), LINE_W'(0));
    check_eq("t5_pmem_write", LINE_W'(bus.pmem_write), LINE_W'(0));
    check_eq("t5_resp", LINE_W'({bus.i_resp, bus.d_resp}), LINE_W'(0));
    check_eq("t5_err", LINE_W'(bus.err), LINE_W'(0));
    rst = 1'b0;
    step();
    check_eq("t5_regrant", LINE_W'(bus.pmem_read), LINE_W'(1));
    drain("t5_drain");

    // Sticky error
    mem_lat = 4;
    bus.pmem_error = 1'b1;
    step();
    bus.pmem_error = 1'b0;
    check_eq("t6_err_set", LINE_W'(bus.err), LINE_W'(1));
    resp_log.delete();
    issue(1, 1'b1, 1'b0, 32'h200, rand_line());
    wait_log(1, 100, "t6_txn1_done");
    issue(0, 1'b0, 1'b1, 32'h240, rand_line());
    wait_log(2, 100, "t6_txn2_done");
    check_eq("t6_err_sticky", LINE_W'(bus.err), LINE_W'(1));
    pulse_reset();
    check_eq("t6_err_cleared", LINE_W'(bus.err), LINE_W'(0));

    // Randomized traffic with spurious resps, errors and occasional resets
    mem_rand = 1;
    spurious = 1;
    scramble = 1;
    req_pct  = 30;
    auto_req[0] = 1; auto_req[1] = 1;
    for (int i = 0; i < 4000; i++) begin
      rst = ($urandom_range(0, 399) == 0);
      bus.pmem_error = ($urandom_range(0, 299) == 0);
      step();
    end
    rst = 1'b0;
    bus.pmem_error = 1'b0;
    auto_req[0] = 0; auto_req[1] = 0;
    spurious = 0;
    step();
    drain("rand_drain");

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
